// File: rtl/imm_pkg.sv
// Shared types, default widths and the fit helper for the immediate narrowing path.
package imm_pkg;

   localparam int unsigned DEF_IN_W  = 32;
   localparam int unsigned DEF_IMM_W = 15;
   localparam int unsigned DEF_CNT_W = 8;

   typedef logic [DEF_IMM_W-1:0] imm_t;
   typedef logic [DEF_IN_W-1:0]  word_t;

   // Largest positive and most negative immediates at the default width
   localparam imm_t IMM_MAX = {1'b0, {(DEF_IMM_W-1){1'b1}}};
   localparam imm_t IMM_MIN = {1'b1, {(DEF_IMM_W-1){1'b0}}};

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // A word fits when every bit from the immediate sign bit upward agrees
   function automatic bit imm_fits(input word_t w);
      logic [DEF_IN_W-DEF_IMM_W:0] upper;
      upper = w[DEF_IN_W-1:DEF_IMM_W-1];
      return (&upper) || (~|upper);
   endfunction

endpackage

// File: rtl/imm_narrow_fit_check.sv
// Combinational fit detection and immediate selection for imm_narrow.
// IMM_NARROW_SATURATE_EN selects clamping of out-of-range values instead of truncation.
module imm_fit_check
   import imm_pkg::*;
#(
   parameter int unsigned IN_W  = DEF_IN_W,
   parameter int unsigned IMM_W = DEF_IMM_W
) (
   input  logic [IN_W-1:0]  i_data,
   output logic             o_fit_c,
   output logic [IMM_W-1:0] o_imm_c
);

   localparam int unsigned UP_W = IN_W - IMM_W + 1;

   logic [UP_W-1:0]  w_upper;
   logic             w_fit;
   logic [IMM_W-1:0] w_trunc;

   assign w_upper = i_data[IN_W-1:IMM_W-1];
   assign w_fit   = (&w_upper) | (~|w_upper);
   assign w_trunc = i_data[IMM_W-1:0];

`ifdef IMM_NARROW_SATURATE_EN
   logic [IMM_W-1:0] w_sat;

   // Clamp toward the sign of the original value
   assign w_sat   = i_data[IN_W-1] ? {1'b1, {(IMM_W-1){1'b0}}}
                                   : {1'b0, {(IMM_W-1){1'b1}}};
   assign o_imm_c = w_fit ? w_trunc : w_sat;
`else
   assign o_imm_c = w_trunc;
`endif

   assign o_fit_c = w_fit;

endmodule

// File: rtl/imm_narrow.sv
// Single-entry registered stage narrowing a signed word to a signed immediate,
// with a saturating overflow counter. Optional macro: IMM_NARROW_SATURATE_EN.
module imm_narrow
   import imm_pkg::*;
#(
   parameter int unsigned IN_W  = DEF_IN_W,
   parameter int unsigned IMM_W = DEF_IMM_W,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IMM_W-1:0] out_imm,
   output logic             out_fit,
   output logic [CNT_W-1:0] ovf_count,
   input  logic             ovf_clr
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_out_valid;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_xfer;
   logic             w_fit;
   logic [IMM_W-1:0] w_imm;
   logic [IMM_W-1:0] r_imm;
   logic             r_fit;
   logic [CNT_W-1:0] r_cnt;

   imm_fit_check #(
      .IN_W  (IN_W),
      .IMM_W (IMM_W)
   ) u_fit_check (
      .i_data  (in_data),
      .o_fit_c (w_fit),
      .o_imm_c (w_imm)
   );

   assign w_accept = in_valid && w_in_ready;
   assign w_xfer   = w_out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
         ST_FULL: begin
            if (w_accept)    w_state_nxt = ST_FULL;
            else if (w_xfer) w_state_nxt = ST_EMPTY;
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // A full stage can still accept when its result leaves this same cycle
   always_comb begin
      w_out_valid = 1'b0;
      w_in_ready  = 1'b1;
      case (r_state)
         ST_FULL: begin
            w_out_valid = 1'b1;
            w_in_ready  = out_ready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_imm <= '0;
         r_fit <= 1'b0;
      end else if (w_accept) begin
         r_imm <= w_imm;
         r_fit <= w_fit;
      end
   end

   // Clear beats a same-cycle increment; the count sticks at its maximum
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (ovf_clr) begin
         r_cnt <= '0;
      end else if (w_accept && !w_fit && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign out_valid = w_out_valid;
   assign in_ready  = w_in_ready;
   assign out_imm   = r_imm;
   assign out_fit   = r_fit;
   assign ovf_count = r_cnt;

endmodule
